// File: rtl/ahbl_uart_rx_pkg.sv
// ahbl_uart_rx_pkg: register map, status bit positions and receiver state encoding
package ahbl_uart_rx_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_PRESC  = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int ST_NE   = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVR  = 2;
  localparam int ST_FE   = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } rx_state_e;

  function automatic logic [31:0] status_word(input logic ne, input logic full,
                                              input logic ovr, input logic fe);
    logic [31:0] w;
    w = '0;
    w[ST_NE]   = ne;
    w[ST_FULL] = full;
    w[ST_OVR]  = ovr;
    w[ST_FE]   = fe;
    return w;
  endfunction

endpackage

// File: rtl/ahbl_uart_rx_fifo.sv
// ahbl_uart_rx_fifo: byte FIFO; a pop frees a slot for a push in the same cycle
module ahbl_uart_rx_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  localparam logic [AW:0] PONE = 1;

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        push_ok, pop_ok;

  assign empty   = wr_ptr_q == rd_ptr_q;
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // advance pointers on accepted push/pop
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PONE : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + PONE : rd_ptr_q;
  end

  // pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // storage needs no reset; empty pointers hide stale entries
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ahbl_uart_rx.sv
// ahbl_uart_rx: AHB-Lite 8N1 UART receiver with 16x oversampling and a receive FIFO
module ahbl_uart_rx
  import ahbl_uart_rx_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] PRESC_RST  = 16'd0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic        HSEL,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  input  logic        rx,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic        act_q, act_d, wr_q, wr_d;
  logic [1:0]  addr_q, addr_d;
  logic [15:0] presc_q, presc_d, pcnt_q, pcnt_d;
  logic        en_q, en_d, ie_q, ie_d, ovr_q, ovr_d, fe_q, fe_d;
  logic        s1_q, s2_q, prev_q;
  rx_state_e   state_q, state_d;
  logic [3:0]  tcnt_q, tcnt_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        push_q, push_d;
  logic        fe_set, ovr_set, wr_en, rd_en, sts_wr, pop, fall, tick;
  logic [7:0]  head;
  logic        empty, full;
  logic [AW:0] count;
  logic        unused;

  assign unused    = ^{HADDR[31:4], HADDR[1:0], HSIZE, HWDATA[31:16], count};
  assign HREADYOUT = 1'b1;
  assign wr_en     = act_q & wr_q;
  assign rd_en     = act_q & ~wr_q;
  assign sts_wr    = wr_en && addr_q == REG_STATUS;
  assign pop       = rd_en && addr_q == REG_DATA && !empty;
  assign ovr_set   = push_q & full & ~pop;
  assign fall      = prev_q & ~s2_q;
  assign tick      = state_q != S_IDLE && pcnt_q == '0;
  assign irq       = ie_q & ~empty;

  assign HRDATA = !rd_en                 ? '0 :
                  addr_q == REG_DATA     ? (empty ? '0 : {24'd0, head}) :
                  addr_q == REG_STATUS   ? status_word(~empty, full, ovr_q, fe_q) :
                  addr_q == REG_PRESC    ? {16'd0, presc_q} :
                                           {30'd0, ie_q, en_q};

  ahbl_uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .push  (push_q),
    .pop   (pop),
    .wdata (shift_q),
    .rdata (head),
    .empty (empty),
    .full  (full),
    .count (count)
  );

  // bus address-phase capture, register writes and sticky error flags
  always_comb begin
    act_d   = HREADY ? (HSEL & HTRANS[1]) : act_q;
    wr_d    = HREADY ? HWRITE : wr_q;
    addr_d  = HREADY ? HADDR[3:2] : addr_q;
    presc_d = (wr_en && addr_q == REG_PRESC) ? HWDATA[15:0] : presc_q;
    en_d    = (wr_en && addr_q == REG_CTRL) ? HWDATA[0] : en_q;
    ie_d    = (wr_en && addr_q == REG_CTRL) ? HWDATA[1] : ie_q;
    ovr_d   = (ovr_q & ~(sts_wr & HWDATA[ST_OVR])) | ovr_set;
    fe_d    = (fe_q & ~(sts_wr & HWDATA[ST_FE])) | fe_set;
  end

  // receive FSM: prescaler reloads only at tick boundaries so PRESC writes never cut a tick short
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    push_d  = 1'b0;
    fe_set  = 1'b0;
    pcnt_d  = (state_q == S_IDLE || pcnt_q == '0) ? presc_q : pcnt_q - 16'd1;
    case (state_q)
      S_IDLE: begin
        tcnt_d = '0;
        bcnt_d = '0;
        if (fall) state_d = S_START;
      end
      S_START: if (tick) begin
        tcnt_d = tcnt_q + 4'd1;
        if (tcnt_q == 4'd7) begin
          tcnt_d  = '0;
          state_d = s2_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: if (tick) begin
        tcnt_d = tcnt_q + 4'd1;
        if (tcnt_q == 4'd15) begin
          shift_d = {s2_q, shift_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: if (tick) begin
        tcnt_d = tcnt_q + 4'd1;
        if (tcnt_q == 4'd15) begin
          state_d = S_IDLE;
          push_d  = s2_q;
          fe_set  = ~s2_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!en_q) begin
      state_d = S_IDLE;
      push_d  = 1'b0;
      fe_set  = 1'b0;
    end
  end

  // all top-level state, including the rx synchronizer and FSM
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      act_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      presc_q <= PRESC_RST;
      en_q    <= 1'b0;
      ie_q    <= 1'b0;
      ovr_q   <= 1'b0;
      fe_q    <= 1'b0;
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= S_IDLE;
      pcnt_q  <= '0;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      push_q  <= 1'b0;
    end else begin
      act_q   <= act_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      presc_q <= presc_d;
      en_q    <= en_d;
      ie_q    <= ie_d;
      ovr_q   <= ovr_d;
      fe_q    <= fe_d;
      s1_q    <= rx;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      push_q  <= push_d;
    end
  end

endmodule

// File: tb/tb_ahbl_uart_rx.sv
// tb_ahbl_uart_rx: directed frames and register accesses with hand-computed expectations
module tb_ahbl_uart_rx;

  logic        HCLK = 1'b0, HRESETn = 1'b0;
  logic [31:0] HADDR = '0, HWDATA = '0;
  logic [1:0]  HTRANS = '0;
  logic [2:0]  HSIZE = 3'd2;
  logic        HWRITE = 1'b0, HREADY = 1'b1, HSEL = 1'b0, rx = 1'b1;
  logic        HREADYOUT, irq;
  logic [31:0] HRDATA;
  logic [31:0] rd;
  int          n_tests = 0, n_fail = 0;

  always #5 HCLK = ~HCLK;

  ahbl_uart_rx #(.FIFO_DEPTH(4), .PRESC_RST(16'd0)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HSIZE     (HSIZE),
    .HWRITE    (HWRITE),
    .HREADY    (HREADY),
    .HSEL      (HSEL),
    .HWDATA    (HWDATA),
    .HREADYOUT (HREADYOUT),
    .HRDATA    (HRDATA),
    .rx        (rx),
    .irq       (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  task automatic ahb_write(input logic [3:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'd0, a};
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    @(negedge HCLK);
  endtask

  task automatic ahb_read(input logic [3:0] a, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'd0, a};
    @(negedge HCLK);
    d = HRDATA;
    HSEL = 1'b0; HTRANS = 2'b00;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    ahb_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input int bc);
    rx = 1'b0;
    repeat (bc) @(negedge HCLK);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bc) @(negedge HCLK);
    end
    rx = stop;
    repeat (bc) @(negedge HCLK);
    rx = 1'b1;
    repeat (4) @(negedge HCLK);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    HRESETn = 1'b1;
    idle(1);
    check("rst_hreadyout", HREADYOUT, 1);
    check("rst_hrdata", HRDATA, 0);
    check("rst_irq", irq, 0);
    rd_chk("rst_status", 4'h4, 0);
    rd_chk("rst_presc", 4'h8, 0);
    rd_chk("rst_ctrl", 4'hC, 0);

    ahb_write(4'h8, 0);
    ahb_write(4'hC, 1);
    rd_chk("ctrl_en", 4'hC, 1);
    send_byte(8'hA5, 1'b1, 16);
    rd_chk("a5_status", 4'h4, 1);
    check("a5_irq_off", irq, 0);
    rd_chk("a5_data", 4'h0, 32'hA5);
    rd_chk("a5_status_after", 4'h4, 0);

    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, 16);
    rd_chk("ovr_status", 4'h4, 7);
    for (int i = 1; i <= 4; i++) rd_chk("ovr_data", 4'h0, i);
    rd_chk("ovr_sticky", 4'h4, 4);
    ahb_write(4'h4, 4);
    rd_chk("ovr_clear", 4'h4, 0);
    rd_chk("empty_read", 4'h0, 0);
    rd_chk("empty_status", 4'h4, 0);

    send_byte(8'h3C, 1'b0, 16);
    rd_chk("fe_status", 4'h4, 8);
    ahb_write(4'h4, 8);
    rd_chk("fe_clear", 4'h4, 0);

    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(30);
    rd_chk("glitch_status", 4'h4, 0);
    send_byte(8'h55, 1'b1, 16);
    rd_chk("glitch_next", 4'h0, 32'h55);

    for (int i = 0; i < 4; i++) send_byte(8'(16 + i), 1'b1, 16);
    rd_chk("full_status", 4'h4, 3);
    fork
      send_byte(8'h14, 1'b1, 16);
      begin
        idle(154);
        ahb_read(4'h0, rd);
      end
    join
    check("pp_head", rd, 32'h10);
    rd_chk("pp_status", 4'h4, 3);
    for (int i = 1; i <= 4; i++) rd_chk("pp_order", 4'h0, 16 + i);
    rd_chk("pp_drained", 4'h4, 0);

    ahb_write(4'hC, 3);
    send_byte(8'h99, 1'b1, 16);
    idle(1);
    check("pre_irq", irq, 1);
    ahb_write(4'h8, 5);
    rd_chk("pre_presc", 4'h8, 5);
    fork
      send_byte(8'h77, 1'b1, 96);
      begin
        idle(96 * 3 + 48);
        HRESETn = 1'b0;
        idle(3);
        HRESETn = 1'b1;
      end
    join
    check("mid_irq", irq, 0);
    check("mid_hrdata", HRDATA, 0);
    check("mid_hreadyout", HREADYOUT, 1);
    rd_chk("mid_status", 4'h4, 0);
    rd_chk("mid_presc", 4'h8, 0);
    rd_chk("mid_ctrl", 4'hC, 0);
    rd_chk("mid_data", 4'h0, 0);

    ahb_write(4'h8, 3);
    ahb_write(4'hC, 3);
    send_byte(8'h81, 1'b1, 64);
    idle(1);
    check("p3_irq", irq, 1);
    rd_chk("p3_data", 4'h0, 32'h81);
    idle(1);
    check("p3_irq_off", irq, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahbl_uart_rx.md
# ahbl_uart_rx

AHB-Lite UART receiver peripheral: the input-side counterpart of the SoC's UART transmitter, placed on a free splitter slot beside it. It samples the asynchronous `rx` line at 16x oversampling and assembles 8N1 frames. Received bytes are buffered in a small FIFO that the Hazard2 CPU drains over AHB-Lite. Status, error flags and an optional interrupt report buffer state to software.

## Interface
- `FIFO_DEPTH`, default 4: receive FIFO entries; power of two, ≥2.
- `PRESC_RST`, default 16'd0: reset value of the PRESC register.
- `HCLK`  in  1  system clock; sole clock.
- `HRESETn`  in  1  asynchronous, active-low reset.
- `HADDR`  in  32  address; only [3:2] decoded.
- `HTRANS`  in  2  transfer type; HTRANS[1]=1 is an active transfer.
- `HSIZE`  in  3  ignored; all accesses are treated as word accesses.
- `HWRITE`  in  1  write=1.
- `HREADY`  in  1  bus ready (address-phase qualifier).
- `HSEL`  in  1  slave select from the splitter.
- `HWDATA`  in  32  write data, sampled in the data phase.
- `HREADYOUT`  out  1  constant 1; the block never inserts wait states.
- `HRDATA`  out  32  read data.
- `rx`  in  1  serial input; idle high; asynchronous to HCLK.
- `irq`  out  1  high when CTRL.IE=1 and the FIFO is non-empty.

## Operation
- Address phase is latched when HSEL & HREADY & HTRANS[1]. Writes are applied and read side effects occur in the following data phase.
- Registers:
  - 0x0 DATA (RO): [7:0] FIFO head; reading pops the FIFO. A read while empty returns 0 and changes no state.
  - 0x4 STATUS: bit0 NE, bit1 FULL, bit2 OVR (sticky), bit3 FE (sticky). Writing 1 to bit2 or bit3 clears that bit.
  - 0x8 PRESC (RW): [15:0].
  - 0xC CTRL (RW): bit0 EN, bit1 IE.
  - Unused bits read 0.
- `rx` passes through a 2-flop synchronizer before use. A tick is generated every PRESC+1 HCLK cycles while EN=1; tick counters reset on entry to IDLE.
- Receive FSM:
  - IDLE: a synchronized falling edge starts a frame → START with the tick count cleared.
  - START: on the 8th tick, sample `rx`. If 0 → DATA; if 1 the edge was a glitch → IDLE.
  - DATA: sample every 16 ticks, 8 bits, LSB first → STOP.
  - STOP: sample after 16 ticks. If 1, push the byte; if the FIFO is full, drop it and set OVR. If 0, set FE and discard the byte. Return to IDLE in either case.
- EN=0 forces IDLE immediately, aborting any frame; the FIFO is untouched.
- A push and a pop in the same cycle both take effect and the count is unchanged. When full, a simultaneous pop and push are both accepted and OVR stays clear.
- Reset, including mid-frame: FSM IDLE, FIFO empty, OVR=FE=0, PRESC=PRESC_RST, CTRL=0.
  - Output reset values: HREADYOUT=1, HRDATA=0, irq=0.

## Timing
- Bit period is 16·(PRESC+1) HCLK cycles. Sampling lands mid-bit ±1 tick.
- From the synchronized falling edge to the push is 8+8·16+16 = 152 ticks, plus 2 cycles of synchronizer latency at the input.
- NE and irq assert in the cycle after the push. HRDATA is valid in the data phase of the read, combinational from the latched address and current state. The pop takes effect at the end of that cycle.
- A back-to-back read of DATA sees the new head.
- PRESC writes take effect on the next tick boundary.

## Structure
- Shared package holds:
  - register offsets: DATA=0, STATUS=1, PRESC=2, CTRL=3 (word index);
  - STATUS bit positions;
  - FSM state encoding: IDLE, START, DATA, STOP.
- Sub-module `ahbl_uart_rx_fifo`: synchronous FIFO with push, pop, head data, empty, full and count. Pointers are log2(FIFO_DEPTH)+1 bits wide.
- Top level contains the AHB-Lite decode, registers, prescaler, synchronizer and FSM.

## Test plan
- Receive 0xA5 with PRESC=0, EN=1 (16-cycle bits) → STATUS reads 0x1, DATA reads 0xA5, then STATUS reads 0x0.
- Send 5 frames 0x01..0x05 with no reads → STATUS=0x7; reads return 0x01..0x04. Write 0x4 to STATUS → OVR clears.
- Frame 0x3C with the stop bit driven 0 → FE=1, NE=0; write 0x8 to STATUS → FE clears.
- Pulse `rx` low for 5 cycles (PRESC=0) → no frame, FSM back in IDLE, STATUS=0. A following valid frame 0x55 is received correctly.
- FIFO full plus a DATA read in the same cycle as a push → count stays 4, OVR=0, read ordering preserved.
- Assert HRESETn low during bit 3 of a frame → all registers reset, irq=0. A subsequent frame 0x81 with PRESC=3, EN=1, IE=1 (64-cycle bits) → irq=1, DATA reads 0x81.
